// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and the grant-selection helper for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

    localparam logic ARB_ID_I = 1'b0;
    localparam logic ARB_ID_D = 1'b1;

    // Returns 1 when the data side should win this arbitration round.
    function automatic logic arb_pick_d(input logic d_req, input logic i_req,
                                        input logic last_grant, input logic fair);
        logic pick_s;
        if (d_req && i_req) begin
            pick_s = fair ? (last_grant == ARB_ID_I) : 1'b1;
        end else begin
            pick_s = d_req;
        end
        return pick_s;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side requests/responses and memory-side handshake for the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_rd;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_stall;
    logic              i_err;

    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;
    logic              d_err;

    logic              hit;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_hit;
    logic              mem_err;
    logic              mem_stall;

    modport slave (
        input  i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata,
        input  mem_rdata, mem_done, mem_hit, mem_err, mem_stall,
        output i_rdata, i_done, i_stall, i_err,
        output d_rdata, d_done, d_stall, d_err, hit,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output i_rd, i_addr, d_rd, d_wr, d_addr, d_wdata,
        output mem_rdata, mem_done, mem_hit, mem_err, mem_stall,
        input  i_rdata, i_done, i_stall, i_err,
        input  d_rdata, d_done, d_stall, d_err, hit,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Watchdog counter for an outstanding memory access; expired flags the TIMEOUT-th waiting cycle.
module arb_wdog #(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMR_W-1:0] cnt_r;

    assign expired = (cnt_r == TMR_W'(TIMEOUT - 1));

    // Wait-cycle counter, restarted on every grant and frozen once expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {TMR_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {TMR_W{1'b0}};
        end else if (en && !expired) begin
            cnt_r <= cnt_r + {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (I) and memory stage (D) with latched requests.
// Build option ARB_FAIR_EN: round-robin on ties instead of strict data-side priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 7
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rd_r;
    logic              wr_r;
    logic              ill_r;

    logic d_req_s;
    logic i_req_s;
    logic illegal_s;
    logic pick_d_s;
    logic grant_i_s;
    logic grant_d_s;
    logic ill_s;
    logic busy_i_s;
    logic busy_d_s;
    logic busy_s;
    logic wdog_exp_s;
    logic expired_s;
    logic end_s;
    logic unused_mem_stall_s;

    assign d_req_s   = bus.d_rd | bus.d_wr;
    assign i_req_s   = bus.i_rd;
    assign illegal_s = bus.d_rd & bus.d_wr;
    assign busy_i_s  = (state_r == ARB_BUSY_I);
    assign busy_d_s  = (state_r == ARB_BUSY_D);
    assign busy_s    = busy_i_s | busy_d_s;
    assign expired_s = busy_s & ~bus.mem_done & wdog_exp_s;
    assign end_s     = busy_s & (bus.mem_done | expired_s);

    // mem_stall is informational; arbitration deliberately ignores it.
    assign unused_mem_stall_s = bus.mem_stall;

`ifdef ARB_FAIR_EN
    logic last_r;

    // Remembers who was served last so a tie goes to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= ARB_ID_I;
        end else if (grant_d_s) begin
            last_r <= ARB_ID_D;
        end else if (grant_i_s) begin
            last_r <= ARB_ID_I;
        end else begin
            last_r <= last_r;
        end
    end

    assign pick_d_s = arb_pick_d(d_req_s, i_req_s, last_r, 1'b1);
`else
    assign pick_d_s = arb_pick_d(d_req_s, i_req_s, ARB_ID_D, 1'b0);
`endif

    // Next-state and grant decode.
    always_comb begin
        state_nxt_s = state_r;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;
        ill_s       = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (pick_d_s) begin
                    if (illegal_s) begin
                        ill_s = 1'b1;
                    end else begin
                        grant_d_s   = 1'b1;
                        state_nxt_s = ARB_BUSY_D;
                    end
                end else if (i_req_s) begin
                    grant_i_s   = 1'b1;
                    state_nxt_s = ARB_BUSY_I;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (bus.mem_done || expired_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // State plus the latched copy of the granted request that drives the memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            ill_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ill_r   <= ill_s;
            if (grant_d_s) begin
                addr_r  <= bus.d_addr;
                wdata_r <= bus.d_wdata;
                rd_r    <= bus.d_rd;
                wr_r    <= bus.d_wr;
            end else if (grant_i_s) begin
                addr_r  <= bus.i_addr;
                wdata_r <= {DATA_W{1'b0}};
                rd_r    <= 1'b1;
                wr_r    <= 1'b0;
            end else if (end_s) begin
                rd_r    <= 1'b0;
                wr_r    <= 1'b0;
            end else begin
                rd_r    <= rd_r;
                wr_r    <= wr_r;
            end
        end
    end

    arb_wdog #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant_i_s | grant_d_s),
        .en      (busy_s & ~bus.mem_done),
        .expired (wdog_exp_s)
    );

    // Strobes are gated on the abort cycle so memory sees the request withdrawn.
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_rd    = rd_r & ~expired_s;
    assign bus.mem_wr    = wr_r & ~expired_s;

    assign bus.i_done  = busy_i_s & (bus.mem_done | expired_s);
    assign bus.d_done  = busy_d_s & (bus.mem_done | expired_s);
    assign bus.i_err   = busy_i_s & ((bus.mem_done & bus.mem_err) | expired_s);
    assign bus.d_err   = (busy_d_s & ((bus.mem_done & bus.mem_err) | expired_s)) | ill_r;
    assign bus.i_rdata = (busy_i_s & bus.mem_done) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.d_rdata = (busy_d_s & bus.mem_done) ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.hit     = busy_s & bus.mem_done & bus.mem_hit;

    assign bus.i_stall = ~rst & i_req_s & ~bus.i_done;
    assign bus.d_stall = ~rst & d_req_s & ~bus.d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single access, collision, errors, timeout, fairness, reset.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (64),
        .TMR_W   (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.i_rd      = 1'b0;
        bus.i_addr    = 16'h0000;
        bus.d_rd      = 1'b0;
        bus.d_wr      = 1'b0;
        bus.d_addr    = 16'h0000;
        bus.d_wdata   = 16'h0000;
        bus.mem_rdata = 16'h0000;
        bus.mem_done  = 1'b0;
        bus.mem_hit   = 1'b0;
        bus.mem_err   = 1'b0;
        bus.mem_stall = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int early;
        logic [15:0] exp_addr;

        rst = 1'b1;
        clear_inputs();

        // Reset state, including stall suppression while held in reset
        @(negedge clk);
        bus.i_rd = 1'b1;
        #1;
        check_eq("rst_mem_rd",  bus.mem_rd,  1'b0);
        check_eq("rst_mem_wr",  bus.mem_wr,  1'b0);
        check_eq("rst_i_stall", bus.i_stall, 1'b0);
        check_eq("rst_d_stall", bus.d_stall, 1'b0);
        check_eq("rst_dones",   {bus.i_done, bus.d_done, bus.i_err, bus.d_err}, 4'b0000);
        bus.i_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // I-only read
        @(negedge clk);
        bus.i_rd = 1'b1; bus.i_addr = 16'h0040;
        #1;
        check_eq("t1_stall_req", bus.i_stall, 1'b1);
        check_eq("t1_no_rd_yet", bus.mem_rd, 1'b0);
        @(negedge clk); #1;
        check_eq("t1_mem_rd",   bus.mem_rd, 1'b1);
        check_eq("t1_mem_addr", bus.mem_addr, 16'h0040);
        check_eq("t1_not_done", bus.i_done, 1'b0);
        @(negedge clk);
        bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF; bus.mem_hit = 1'b1;
        #1;
        check_eq("t1_i_done",  bus.i_done, 1'b1);
        check_eq("t1_i_rdata", bus.i_rdata, 16'hBEEF);
        check_eq("t1_hit",     bus.hit, 1'b1);
        check_eq("t1_unstall", bus.i_stall, 1'b0);
        check_eq("t1_d_done",  bus.d_done, 1'b0);
        @(negedge clk);
        bus.mem_done = 1'b0; bus.mem_hit = 1'b0; bus.i_rd = 1'b0;
        #1;
        check_eq("t1_idle_rd", bus.mem_rd, 1'b0);

        // Collision: D store first, then I read after an idle gap
        @(negedge clk);
        bus.i_rd = 1'b1; bus.i_addr = 16'h0200;
        bus.d_wr = 1'b1; bus.d_addr = 16'h0100; bus.d_wdata = 16'h1234;
        #1;
        check_eq("t2_d_stall", bus.d_stall, 1'b1);
        @(negedge clk);
        bus.d_addr = 16'h0999; bus.d_wdata = 16'hFFFF;
        #1;
        check_eq("t2_mem_wr",    bus.mem_wr, 1'b1);
        check_eq("t2_mem_rd",    bus.mem_rd, 1'b0);
        check_eq("t2_addr_held", bus.mem_addr, 16'h0100);
        check_eq("t2_data_held", bus.mem_wdata, 16'h1234);
        check_eq("t2_i_stall",   bus.i_stall, 1'b1);
        @(negedge clk);
        bus.mem_done = 1'b1;
        #1;
        check_eq("t2_d_done", {bus.d_done, bus.i_done}, 2'b10);
        check_eq("t2_d_unstall", bus.d_stall, 1'b0);
        @(negedge clk);
        bus.mem_done = 1'b0; bus.d_wr = 1'b0;
        #1;
        check_eq("t2_gap", {bus.mem_rd, bus.mem_wr}, 2'b00);
        check_eq("t2_i_wait", bus.i_stall, 1'b1);
        @(negedge clk); #1;
        check_eq("t2_i_rd",   bus.mem_rd, 1'b1);
        check_eq("t2_i_addr", bus.mem_addr, 16'h0200);
        bus.mem_done = 1'b1; bus.mem_rdata = 16'h5A5A;
        #1;
        check_eq("t2_i_done",  bus.i_done, 1'b1);
        check_eq("t2_i_rdata", bus.i_rdata, 16'h5A5A);
        @(negedge clk);
        clear_inputs();

        // D store completing with mem_err
        @(negedge clk);
        bus.d_wr = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 16'hAAAA;
        @(negedge clk);
        bus.mem_done = 1'b1; bus.mem_err = 1'b1; bus.mem_hit = 1'b1;
        #1;
        check_eq("t5_d_err_done", {bus.d_err, bus.d_done}, 2'b11);
        check_eq("t5_hit",        bus.hit, 1'b1);
        check_eq("t5_i_clean",    {bus.i_err, bus.i_done}, 2'b00);
        @(negedge clk);
        clear_inputs();
        #1;
        check_eq("t5_err_once", bus.d_err, 1'b0);

        // Illegal simultaneous read+write
        @(negedge clk);
        bus.d_rd = 1'b1; bus.d_wr = 1'b1;
        #1;
        check_eq("ill_no_err_yet", bus.d_err, 1'b0);
        @(negedge clk);
        bus.d_rd = 1'b0; bus.d_wr = 1'b0;
        #1;
        check_eq("ill_err",    bus.d_err, 1'b1);
        check_eq("ill_no_mem", {bus.mem_rd, bus.mem_wr, bus.d_done}, 3'b000);
        @(negedge clk); #1;
        check_eq("ill_pulse_end", {bus.d_err, bus.mem_rd, bus.mem_wr}, 3'b000);

        // Watchdog: D read with no mem_done aborts on the 64th busy cycle
        @(negedge clk);
        bus.d_rd = 1'b1; bus.d_addr = 16'h0500; bus.mem_rdata = 16'hFFFF; bus.mem_stall = 1'b1;
        early = 0;
        for (int k = 1; k <= 63; k++) begin
            @(negedge clk); #1;
            if (!(bus.mem_rd === 1'b1 && bus.d_done === 1'b0 && bus.d_err === 1'b0)) early++;
        end
        check_eq("t4_hold_63", early, 0);
        @(negedge clk); #1;
        check_eq("t4_done_err", {bus.d_done, bus.d_err}, 2'b11);
        check_eq("t4_rdata0",   bus.d_rdata, 16'h0000);
        check_eq("t4_drop_rd",  bus.mem_rd, 1'b0);
        bus.d_rd = 1'b0;
        @(negedge clk); #1;
        check_eq("t4_idle", {bus.mem_rd, bus.d_done, bus.d_err}, 3'b000);
        clear_inputs();

        // Both requesters held: grant order depends on fairness build
        do_reset();
        @(negedge clk);
        bus.i_rd = 1'b1; bus.i_addr = 16'h0300;
        bus.d_rd = 1'b1; bus.d_addr = 16'h0400;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk); #1;
`ifdef ARB_FAIR_EN
            exp_addr = (g % 2 == 1) ? 16'h0300 : 16'h0400;
`else
            exp_addr = 16'h0400;
`endif
            check_eq("t3_grant_addr", bus.mem_addr, exp_addr);
            bus.mem_done = 1'b1;
            #1;
            check_eq("t3_grant_done", {bus.i_done, bus.d_done},
                     (exp_addr == 16'h0300) ? 2'b10 : 2'b01);
            @(negedge clk);
            bus.mem_done = 1'b0;
            if (g == 5) begin
                bus.i_rd = 1'b0;
                bus.d_rd = 1'b0;
            end
        end
        clear_inputs();

        // Reset asserted mid BUSY_D
        @(negedge clk);
        bus.d_wr = 1'b1; bus.d_addr = 16'h0600; bus.d_wdata = 16'h0042;
        @(negedge clk); #1;
        check_eq("t6_busy_wr", bus.mem_wr, 1'b1);
        #2;
        bus.i_rd = 1'b1; bus.i_addr = 16'h0700;
        rst = 1'b1;
        #1;
        check_eq("t6_wr_drop", bus.mem_wr, 1'b0);
        check_eq("t6_stalls",  {bus.i_stall, bus.d_stall}, 2'b00);
        @(negedge clk);
        rst = 1'b0; bus.d_wr = 1'b0;
        #1;
        check_eq("t6_idle", {bus.mem_rd, bus.mem_wr}, 2'b00);
        check_eq("t6_i_stall", bus.i_stall, 1'b1);
        @(negedge clk); #1;
        check_eq("t6_regrant", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0700});
        bus.mem_done = 1'b1;
        #1;
        check_eq("t6_i_done", bus.i_done, 1'b1);
        @(negedge clk);
        clear_inputs();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
